// File: rtl/psg_voice_scheduler.sv
// rtl/psg_voice_scheduler.sv - time-multiplexed PSG voice scheduler and square-wave mixer
//
// Purpose: on each sample_tick, commit shadow config to active regs, then step one
// voice per clock through a shared phase adder, sum the square-wave volumes, and
// present the mixed sample with a one-cycle valid strobe.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   sample_tick   frame-start strobe (dropped and flagged if busy)
//   cfg_we        shadow register write strobe
//   cfg_addr      {voice, field}; field 0 = freq, field 1 = {en, vol}
//   cfg_data      write data
//   ovr_clr       clears the sticky overrun flag
//   busy          frame in progress (state != IDLE)
//   sq_out        per-voice square bit (phase MSB)
//   mix_out       last completed mixed sample
//   mix_valid     one-cycle strobe when mix_out is new
//   overrun       sticky dropped-tick flag
module psg_voice_scheduler #(
  parameter int VOICES = 4,
  parameter int ACC_W  = 16,
  parameter int VOL_W  = 4,
  localparam int VI_W  = $clog2(VOICES),
  localparam int MIX_W = VOL_W + VI_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              cfg_we,
  input  logic [VI_W:0]     cfg_addr,
  input  logic [ACC_W-1:0]  cfg_data,
  input  logic              ovr_clr,
  output logic              busy,
  output logic [VOICES-1:0] sq_out,
  output logic [MIX_W-1:0]  mix_out,
  output logic              mix_valid,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [ACC_W-1:0] freq_sh [VOICES];
  logic [VOL_W-1:0] vol_sh  [VOICES];
  logic             en_sh   [VOICES];
  logic [ACC_W-1:0] freq    [VOICES];
  logic [VOL_W-1:0] vol     [VOICES];
  logic             en      [VOICES];
  logic [ACC_W-1:0] phase   [VOICES];

  logic [VI_W-1:0]  idx;
  logic [MIX_W-1:0] sum;

  logic             commit;
  logic             step;
  logic             last;
  logic [ACC_W-1:0] phase_nxt;
  logic [MIX_W-1:0] contrib;
  logic [MIX_W-1:0] sum_nxt;

  logic [VI_W-1:0]  wr_voice;
  assign wr_voice = cfg_addr[VI_W:1];

  // Shadow registers accept writes in any state; a write coinciding with the
  // commit edge lands here after the copy, so it applies from the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        freq_sh[i] <= '0;
        vol_sh[i]  <= '0;
        en_sh[i]   <= 1'b0;
      end
    end else if (cfg_we) begin
      if (!cfg_addr[0]) begin
        freq_sh[wr_voice] <= cfg_data;
      end else begin
        vol_sh[wr_voice] <= cfg_data[VOL_W-1:0];
        en_sh[wr_voice]  <= cfg_data[VOL_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    commit    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    mix_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          commit  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (idx == VI_W'(VOICES - 1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        mix_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared phase adder; a disabled voice keeps its phase and contributes nothing.
  always_comb begin
    phase_nxt = en[idx] ? phase[idx] + freq[idx] : phase[idx];
    contrib   = (en[idx] && phase_nxt[ACC_W-1]) ? MIX_W'(vol[idx]) : '0;
    sum_nxt   = sum + contrib;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        freq[i]  <= '0;
        vol[i]   <= '0;
        en[i]    <= 1'b0;
        phase[i] <= '0;
      end
      idx     <= '0;
      sum     <= '0;
      mix_out <= '0;
    end else begin
      if (commit) begin
        for (int i = 0; i < VOICES; i++) begin
          freq[i] <= freq_sh[i];
          vol[i]  <= vol_sh[i];
          en[i]   <= en_sh[i];
        end
        idx <= '0;
        sum <= '0;
      end
      if (step) begin
        phase[idx] <= phase_nxt;
        sum        <= sum_nxt;
        idx        <= idx + 1'b1;
        if (last) mix_out <= sum_nxt;
      end
    end
  end

  // A dropped tick takes priority over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      overrun <= 1'b0;
    else if (sample_tick && busy) overrun <= 1'b1;
    else if (ovr_clr)             overrun <= 1'b0;
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_sq
    assign sq_out[g] = phase[g][ACC_W-1];
  end

endmodule

// File: tb/tb_psg_voice_scheduler.sv
// tb/tb_psg_voice_scheduler.sv - directed self-checking bench for psg_voice_scheduler
module tb_psg_voice_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_tick;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        ovr_clr;
  logic        busy;
  logic [3:0]  sq_out;
  logic [5:0]  mix_out;
  logic        mix_valid;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;
  int vcount;

  psg_voice_scheduler #(.VOICES(4), .ACC_W(16), .VOL_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .ovr_clr     (ovr_clr),
    .busy        (busy),
    .sq_out      (sq_out),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int voice, input int field, input logic [15:0] data);
    cfg_we   = 1'b1;
    cfg_addr = {voice[1:0], field[0]};
    cfg_data = data;
    cyc(1);
    cfg_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
  endtask

  // Tick is sampled at edge t; result at edge t+4, back to IDLE at t+5.
  // Any cfg_we the caller has set up is presented in the tick cycle.
  task automatic frame(input string tag, input logic [5:0] exp_mix, input logic [3:0] exp_sq);
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
    cfg_we      = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    cyc(3);
    chk({tag, "_early_valid"}, 32'(mix_valid), 32'd0);
    cyc(1);
    chk({tag, "_valid"}, 32'(mix_valid), 32'd1);
    chk({tag, "_mix"}, 32'(mix_out), 32'(exp_mix));
    chk({tag, "_sq"}, 32'(sq_out), 32'(exp_sq));
    cyc(1);
    chk({tag, "_valid_off"}, 32'(mix_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; ovr_clr = 1'b0;
    cyc(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mix", 32'(mix_out), 32'd0);
    chk("rst_valid", 32'(mix_valid), 32'd0);
    chk("rst_sq", 32'(sq_out), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    cyc(1);

    // Single voice: 0x8000 step, vol 15
    wr(0, 0, 16'h8000);
    wr(0, 1, 16'h001F);
    frame("single1", 6'd15, 4'b0001);
    frame("single2", 6'd0, 4'b0000);
    frame("single3", 6'd15, 4'b0001);

    // Reset mid-RUN while mix_out still holds 15
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
    cyc(2);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mix", 32'(mix_out), 32'd0);
    chk("midrst_valid", 32'(mix_valid), 32'd0);
    chk("midrst_sq", 32'(sq_out), 32'd0);
    cyc(1);
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (mix_valid) vcount++;
    end
    chk("midrst_no_valid", 32'(vcount), 32'd0);
    wr(0, 0, 16'h8000);
    wr(0, 1, 16'h001F);
    frame("after_rst", 6'd15, 4'b0001);

    // Four voices, 0x4000 step, vols 1..4
    do_reset();
    for (int v = 0; v < 4; v++) begin
      wr(v, 0, 16'h4000);
      wr(v, 1, 16'(16'h0010 | (v + 1)));
    end
    frame("four1", 6'd0, 4'h0);
    frame("four2", 6'd10, 4'hF);
    frame("four3", 6'd10, 4'hF);
    frame("four4", 6'd0, 4'h0);

    // Write coinciding with the tick applies from the next frame
    do_reset();
    wr(1, 0, 16'hFFFF);
    wr(1, 1, 16'h0010);
    cfg_we = 1'b1; cfg_addr = 3'b011; cfg_data = 16'h0017;
    frame("commit_old", 6'd0, 4'b0010);
    frame("commit_new", 6'd7, 4'b0010);

    // Disabled voice holds phase (MSB stays 1) and contributes 0
    do_reset();
    wr(2, 0, 16'h8000);
    wr(2, 1, 16'h001F);
    frame("dis_pre", 6'd15, 4'b0100);
    wr(2, 0, 16'h1234);
    wr(2, 1, 16'h000F);
    frame("dis1", 6'd0, 4'b0100);
    frame("dis2", 6'd0, 4'b0100);

    // Overrun: second tick three edges after the first
    do_reset();
    wr(0, 0, 16'h8000);
    wr(0, 1, 16'h0015);
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
    chk("ovr_before", 32'(overrun), 32'd0);
    cyc(2);
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
    chk("ovr_set", 32'(overrun), 32'd1);
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (mix_valid) begin
        vcount++;
        chk("ovr_mix", 32'(mix_out), 32'd5);
      end
      cyc(1);
    end
    chk("ovr_one_valid", 32'(vcount), 32'd1);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    chk("ovr_idle", 32'(busy), 32'd0);
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);
    sample_tick = 1'b1;
    cyc(1);
    ovr_clr = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
    ovr_clr = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 32'd1);
    cyc(6);
    chk("ovr_hold", 32'(overrun), 32'd1);
    chk("ovr_mix2", 32'(mix_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
